// File: rtl/gfx_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// gfx_pkg
// Shared constants and types for the graphics command path.
//   GFX_H_RES / GFX_V_RES     : visible raster size; origins at or beyond
//                               these limits are rejected by the scheduler.
//   ADDR_SCHED_TIMEOUT        : default watchdog limit (cycles from start
//                               strobe to generation done).
//   ADDR_SCHED_TMR_W          : default watchdog counter width.
//   as_state_t                : 2-bit state encoding of addr_cmd_scheduler.
//   coord_in_range()          : origin range test used at grant time.
// -----------------------------------------------------------------------------
package gfx_pkg;

    localparam int GFX_H_RES          = 640;
    localparam int GFX_V_RES          = 480;
    localparam int ADDR_SCHED_TIMEOUT = 4096;
    localparam int ADDR_SCHED_TMR_W   = 13;

    typedef enum logic [1:0] {
        AS_IDLE      = 2'd0,
        AS_ISSUE     = 2'd1,
        AS_WAIT_ADDR = 2'd2,
        AS_WAIT_GEN  = 2'd3
    } as_state_t;

    // True when (x, y) lies inside an h_lim x v_lim raster. The coordinates
    // are zero-extended so the compare is done on non-negative values.
    function automatic logic coord_in_range(
        input logic [15:0] x,
        input logic [15:0] y,
        input int          h_lim,
        input int          v_lim
    );
        int x_ext;
        int y_ext;
        x_ext = int'({16'd0, x});
        y_ext = int'({16'd0, y});
        return (x_ext < h_lim) && (y_ext < v_lim);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a one-bit "last granted" pointer.
// Ports:
//   clk      in   system clock
//   rst_     in   asynchronous active-low reset; pointer resets to "req1 last"
//                 so req0 wins the first tie
//   req      in   [1:0] request vector (bit0 = requester 0)
//   advance  in   commit the current grant: pointer moves to the winner
//   gnt      out  [1:0] one-hot grant, combinational from req and pointer
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1 = requester 1 was granted last, so requester 0 has priority on a tie.
    logic last_reg;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_reg ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            last_reg <= 1'b1;
        end else if (advance && (|req)) begin
            last_reg <= gnt[1];
        end
    end

endmodule

// File: rtl/addr_cmd_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// addr_cmd_scheduler
// Accepts draw commands from two requesters (0 = decode engine, 1 = fill/blit
// engine), arbitrates round-robin, range-checks the origin, starts the
// addressing engine with a one-cycle strobe and then waits for address
// completion and generation completion before taking the next command.
// A watchdog aborts a command whose engines stall.
// Ports:
//   clk, rst_                       clock, asynchronous active-low reset
//   reqN_valid/origx/origy (in)     command from requester N, held until ack
//   reqN_ack (out)                  one-cycle consume pulse to requester N
//   addr_start_strobe (out)         one-cycle start to the addressing engine
//   cmd_data_origx/origy (out)      latched origin, stable until next accept
//   gen_start_strobe, gen_done (in) engine progress / completion
//   grant_id (out)                  requester of the current/last command
//   busy (out)                      scheduler is not idle
//   err_range, err_timeout (out)    one-cycle error pulses
// -----------------------------------------------------------------------------
module addr_cmd_scheduler
    import gfx_pkg::*;
#(
    parameter int H_RES   = GFX_H_RES,
    parameter int V_RES   = GFX_V_RES,
    parameter int TIMEOUT = ADDR_SCHED_TIMEOUT,
    parameter int TMR_W   = ADDR_SCHED_TMR_W
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        req0_valid,
    input  logic [15:0] req0_origx,
    input  logic [15:0] req0_origy,
    output logic        req0_ack,
    input  logic        req1_valid,
    input  logic [15:0] req1_origx,
    input  logic [15:0] req1_origy,
    output logic        req1_ack,
    output logic        addr_start_strobe,
    output logic [15:0] cmd_data_origx,
    output logic [15:0] cmd_data_origy,
    input  logic        gen_start_strobe,
    input  logic        gen_done,
    output logic        grant_id,
    output logic        busy,
    output logic        err_range,
    output logic        err_timeout
);

    as_state_t        state_reg;
    logic [TMR_W-1:0] wdog_reg;

    logic             arb_en;
    logic [1:0]       req_vec;
    logic [1:0]       gnt;
    logic [15:0]      sel_x;
    logic [15:0]      sel_y;
    logic             sel_ok;
    logic             wdog_expired;

    // A requester keeps valid high during its ack cycle, so arbitration is
    // held off while an ack is being driven; otherwise a dropped (range
    // error) command would be granted a second time.
    assign arb_en  = (state_reg == AS_IDLE) && !req0_ack && !req1_ack;
    assign req_vec = arb_en ? {req1_valid, req0_valid} : 2'b00;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_    (rst_),
        .req     (req_vec),
        .advance (arb_en),
        .gnt     (gnt)
    );

    assign sel_x  = gnt[1] ? req1_origx : req0_origx;
    assign sel_y  = gnt[1] ? req1_origy : req0_origy;
    assign sel_ok = coord_in_range(sel_x, sel_y, H_RES, V_RES);

    // Greater-or-equal so that a command which moved to WAIT_GEN exactly at
    // the limit is still aborted on the next stalled cycle.
    assign wdog_expired = (wdog_reg >= TMR_W'(TIMEOUT - 1));

    assign busy = (state_reg != AS_IDLE);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg         <= AS_IDLE;
            wdog_reg          <= '0;
            req0_ack          <= 1'b0;
            req1_ack          <= 1'b0;
            addr_start_strobe <= 1'b0;
            cmd_data_origx    <= 16'd0;
            cmd_data_origy    <= 16'd0;
            grant_id          <= 1'b0;
            err_range         <= 1'b0;
            err_timeout       <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            req0_ack          <= 1'b0;
            req1_ack          <= 1'b0;
            addr_start_strobe <= 1'b0;
            err_range         <= 1'b0;
            err_timeout       <= 1'b0;

            case (state_reg)
                AS_IDLE: begin
                    if (|gnt) begin
                        req0_ack <= gnt[0];
                        req1_ack <= gnt[1];
                        grant_id <= gnt[1];
                        if (sel_ok) begin
                            cmd_data_origx <= sel_x;
                            cmd_data_origy <= sel_y;
                            state_reg      <= AS_ISSUE;
                        end else begin
                            // Out-of-range command is consumed and dropped.
                            err_range <= 1'b1;
                        end
                    end
                end

                AS_ISSUE: begin
                    // Strobe becomes visible together with the first
                    // WAIT_ADDR cycle; the watchdog counts from there.
                    addr_start_strobe <= 1'b1;
                    wdog_reg          <= '0;
                    state_reg         <= AS_WAIT_ADDR;
                end

                AS_WAIT_ADDR: begin
                    wdog_reg <= wdog_reg + TMR_W'(1);
                    if (gen_start_strobe && gen_done) begin
                        state_reg <= AS_IDLE;
                    end else if (gen_start_strobe) begin
                        state_reg <= AS_WAIT_GEN;
                    end else if (wdog_expired) begin
                        err_timeout <= 1'b1;
                        state_reg   <= AS_IDLE;
                    end
                end

                AS_WAIT_GEN: begin
                    wdog_reg <= wdog_reg + TMR_W'(1);
                    if (gen_done) begin
                        state_reg <= AS_IDLE;
                    end else if (wdog_expired) begin
                        err_timeout <= 1'b1;
                        state_reg   <= AS_IDLE;
                    end
                end

                default: begin
                    state_reg <= AS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_cmd_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_addr_cmd_scheduler
// Bench for addr_cmd_scheduler with a 16-cycle watchdog. Commands are run
// one at a time; expected grant, error and timing follow from a small model
// of the round-robin pointer, the raster limits and the watchdog deadline
// (16 cycles after the start strobe).
// -----------------------------------------------------------------------------
module tb_addr_cmd_scheduler;

    localparam int TB_TIMEOUT = 16;

    logic        clk;
    logic        rst_;
    logic        req0_valid;
    logic [15:0] req0_origx;
    logic [15:0] req0_origy;
    logic        req0_ack;
    logic        req1_valid;
    logic [15:0] req1_origx;
    logic [15:0] req1_origy;
    logic        req1_ack;
    logic        addr_start_strobe;
    logic [15:0] cmd_data_origx;
    logic [15:0] cmd_data_origy;
    logic        gen_start_strobe;
    logic        gen_done;
    logic        grant_id;
    logic        busy;
    logic        err_range;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    // Reference state
    bit          m_rr_last;   // 1 = requester 1 granted last
    logic [15:0] m_x;
    logic [15:0] m_y;

    typedef struct {
        bit          v0;
        logic [15:0] x0;
        logic [15:0] y0;
        bit          v1;
        logic [15:0] x1;
        logic [15:0] y1;
        int          gs;    // cycle (relative to start strobe) of gen_start_strobe
        int          gd;    // cycle of gen_done
        bit          eg;    // expected grant
        bit          erng;  // expected range error
        bit          etmo;  // expected watchdog abort
    } vec_t;

    vec_t vecs[13];

    addr_cmd_scheduler #(
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst_              (rst_),
        .req0_valid        (req0_valid),
        .req0_origx        (req0_origx),
        .req0_origy        (req0_origy),
        .req0_ack          (req0_ack),
        .req1_valid        (req1_valid),
        .req1_origx        (req1_origx),
        .req1_origy        (req1_origy),
        .req1_ack          (req1_ack),
        .addr_start_strobe (addr_start_strobe),
        .cmd_data_origx    (cmd_data_origx),
        .cmd_data_origy    (cmd_data_origy),
        .gen_start_strobe  (gen_start_strobe),
        .gen_done          (gen_done),
        .grant_id          (grant_id),
        .busy              (busy),
        .err_range         (err_range),
        .err_timeout       (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout bench did not finish, actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Spec-level watchdog rule: an engine event at or before cycle 15 after
    // the strobe is in time; anything later means an abort seen at cycle 16.
    function automatic bit model_tmo(input int gs, input int gd);
        return (gs > TB_TIMEOUT - 1) || (gd > TB_TIMEOUT - 1);
    endfunction

    task automatic run_cmd(input vec_t v);
        logic [15:0] ex;
        logic [15:0] ey;
        int          end_c;
        bit          fin;
        ex = v.eg ? v.x1 : v.x0;
        ey = v.eg ? v.y1 : v.y0;
        req0_valid = v.v0;
        req0_origx = v.x0;
        req0_origy = v.y0;
        req1_valid = v.v1;
        req1_origx = v.x1;
        req1_origy = v.y1;
        step();
        // Ack cycle
        chk("ack0", req0_ack, !v.eg);
        chk("ack1", req1_ack, v.eg);
        chk("err_range", err_range, v.erng);
        chk("grant_id", grant_id, v.eg);
        chk("busy_issue", busy, !v.erng);
        chk("strobe_early", addr_start_strobe, 0);
        chk("cmd_x_ack", cmd_data_origx, v.erng ? m_x : ex);
        chk("cmd_y_ack", cmd_data_origy, v.erng ? m_y : ey);
        m_rr_last = v.eg;
        if (!v.erng) begin
            m_x = ex;
            m_y = ey;
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("ack0_pulse", req0_ack, 0);
        chk("ack1_pulse", req1_ack, 0);
        chk("err_range_pulse", err_range, 0);
        if (v.erng) begin
            chk("busy_drop", busy, 0);
            chk("no_strobe", addr_start_strobe, 0);
            step();
            chk("no_strobe2", addr_start_strobe, 0);
            chk("no_reack", req0_ack | req1_ack, 0);
            chk("cmd_x_kept", cmd_data_origx, m_x);
            $display("txn %0d grant=%0d x=%0d y=%0d dropped_range", txn_no, v.eg, ex, ey);
            txn_no++;
            return;
        end
        // Strobe cycle (cycle 0)
        chk("strobe", addr_start_strobe, 1);
        chk("busy_strobe", busy, 1);
        chk("cmd_x", cmd_data_origx, m_x);
        chk("cmd_y", cmd_data_origy, m_y);
        end_c = v.etmo ? TB_TIMEOUT : v.gd + 1;
        gen_start_strobe = (v.gs == 0);
        gen_done         = (v.gd == 0);
        for (int c = 1; c <= end_c; c++) begin
            step();
            fin = (c == end_c);
            chk("busy_wait", busy, !fin);
            chk("err_timeout", err_timeout, fin && v.etmo);
            chk("strobe_once", addr_start_strobe, 0);
            chk("cmd_x_hold", cmd_data_origx, m_x);
            gen_start_strobe = !fin && (c == v.gs);
            gen_done         = !fin && (c == v.gd);
        end
        step();
        chk("err_timeout_pulse", err_timeout, 0);
        chk("busy_idle", busy, 0);
        $display("txn %0d grant=%0d x=%0d y=%0d gs=%0d gd=%0d timeout=%0d",
                 txn_no, v.eg, ex, ey, v.gs, v.gd, v.etmo);
        txn_no++;
    endtask

    initial begin
        vec_t rv;
        bit   gx;

        // gs, gd relative to start strobe; tie table starts right after reset
        vecs[0]  = '{1'b1, 16'd10,  16'd10,  1'b1, 16'd20,  16'd20,  1,  3,  1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 16'd10,  16'd10,  1'b1, 16'd20,  16'd20,  1,  2,  1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 16'd11,  16'd12,  1'b1, 16'd21,  16'd22,  0,  1,  1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 16'd11,  16'd12,  1'b1, 16'd21,  16'd22,  2,  5,  1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 16'd100, 16'd50,  1'b0, 16'd0,   16'd0,   3,  13, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 16'd0,   16'd0,   1'b1, 16'd640, 16'd0,   0,  0,  1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 16'd0,   16'd0,   1'b1, 16'd0,   16'd480, 0,  0,  1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 16'd0,   16'd0,   1'b1, 16'd639, 16'd479, 0,  0,  1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 16'd5,   16'd5,   1'b0, 16'd0,   16'd0,   20, 20, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 16'd1,   16'd2,   1'b0, 16'd0,   16'd0,   2,  2,  1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 16'd0,   16'd0,   1'b1, 16'd3,   16'd4,   15, 15, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 16'd7,   16'd8,   1'b0, 16'd0,   16'd0,   4,  15, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 16'd0,   16'd0,   1'b1, 16'd9,   16'd9,   4,  16, 1'b1, 1'b0, 1'b1};

        rst_ = 1'b1;
        req0_valid = 1'b0; req0_origx = 16'd0; req0_origy = 16'd0;
        req1_valid = 1'b0; req1_origx = 16'd0; req1_origy = 16'd0;
        gen_start_strobe = 1'b0;
        gen_done = 1'b0;
        m_rr_last = 1'b1;
        m_x = 16'd0;
        m_y = 16'd0;

        // Reset with a tie already pending
        #2 rst_ = 1'b0;
        req0_valid = 1'b1; req0_origx = 16'd10; req0_origy = 16'd10;
        req1_valid = 1'b1; req1_origx = 16'd20; req1_origy = 16'd20;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ack", {req1_ack, req0_ack}, 0);
        chk("rst_strobe", addr_start_strobe, 0);
        chk("rst_cmd", {cmd_data_origx, cmd_data_origy}, 0);
        chk("rst_errs", {err_range, err_timeout, grant_id}, 0);
        step();
        step();
        chk("rst_hold_ack", {req1_ack, req0_ack}, 0);
        rst_ = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_cmd(vecs[i]);
        end

        // Stray engine signals while idle are ignored
        gen_start_strobe = 1'b1;
        gen_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stray_busy", busy, 0);
            chk("stray_strobe", addr_start_strobe, 0);
            chk("stray_tmo", err_timeout, 0);
        end
        gen_start_strobe = 1'b0;
        gen_done = 1'b0;
        step();

        // Async reset in WAIT_GEN, then a pending tie after release
        req0_valid = 1'b1; req0_origx = 16'd30; req0_origy = 16'd40;
        step();
        chk("mid_ack0", req0_ack, 1);
        step();
        req0_valid = 1'b0;
        chk("mid_strobe", addr_start_strobe, 1);
        gen_start_strobe = 1'b1;
        step();
        gen_start_strobe = 1'b0;
        step();
        chk("mid_busy", busy, 1);
        req0_valid = 1'b1; req0_origx = 16'd50; req0_origy = 16'd60;
        req1_valid = 1'b1; req1_origx = 16'd70; req1_origy = 16'd80;
        #2 rst_ = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ack", {req1_ack, req0_ack}, 0);
        chk("arst_strobe", addr_start_strobe, 0);
        chk("arst_cmd", {cmd_data_origx, cmd_data_origy}, 0);
        chk("arst_gid", grant_id, 0);
        chk("arst_errs", {err_range, err_timeout}, 0);
        step();
        chk("arst_hold", {req1_ack, req0_ack, busy}, 0);
        rst_ = 1'b1;
        step();
        chk("post_rst_ack0", req0_ack, 1);
        chk("post_rst_ack1", req1_ack, 0);
        chk("post_rst_gid", grant_id, 0);
        chk("post_rst_cmd", {cmd_data_origx, cmd_data_origy}, {16'd50, 16'd60});
        step();
        req0_valid = 1'b0;
        chk("post_rst_strobe", addr_start_strobe, 1);
        gen_start_strobe = 1'b1;
        gen_done = 1'b1;
        step();
        gen_start_strobe = 1'b0;
        gen_done = 1'b0;
        chk("same_cycle_idle", busy, 0);
        chk("same_cycle_noerr", err_timeout, 0);
        step();
        chk("held_ack1", req1_ack, 1);
        chk("held_gid", grant_id, 1);
        chk("held_cmd", {cmd_data_origx, cmd_data_origy}, {16'd70, 16'd80});
        step();
        req1_valid = 1'b0;
        chk("held_strobe", addr_start_strobe, 1);
        gen_start_strobe = 1'b1;
        gen_done = 1'b1;
        step();
        gen_start_strobe = 1'b0;
        gen_done = 1'b0;
        chk("held_done", busy, 0);
        step();
        m_rr_last = 1'b1;
        m_x = 16'd70;
        m_y = 16'd80;

        // Randomized commands against the reference model
        for (int i = 0; i < 60; i++) begin
            rv.v0 = 1'($urandom_range(0, 1));
            rv.v1 = 1'($urandom_range(0, 1));
            if (!rv.v0 && !rv.v1) rv.v0 = 1'b1;
            rv.x0 = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(640, 700)) : 16'($urandom_range(0, 639));
            rv.y0 = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(480, 520)) : 16'($urandom_range(0, 479));
            rv.x1 = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(640, 700)) : 16'($urandom_range(0, 639));
            rv.y1 = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(480, 520)) : 16'($urandom_range(0, 479));
            rv.gs = int'($urandom_range(0, 18));
            rv.gd = (rv.gs == 15) ? 15 : rv.gs + int'($urandom_range(0, 3));
            gx = (rv.v0 && rv.v1) ? !m_rr_last : rv.v1;
            rv.eg   = gx;
            rv.erng = gx ? ((rv.x1 >= 16'd640) || (rv.y1 >= 16'd480))
                         : ((rv.x0 >= 16'd640) || (rv.y0 >= 16'd480));
            rv.etmo = model_tmo(rv.gs, rv.gd);
            run_cmd(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
